// File: rtl/fp_pkg.sv
`timescale 1ns/1ps
// fp_pkg: shared binary32 definitions for the integer-to-float datapath.
//   FP32_BIAS / FP32_EXP_W / FP32_FRAC_W : IEEE-754 single-precision field constants
//   fp32_t   : packed {sign, exp, frac} view of a binary32 word
//   i2f_s1_t : payload carried from stage 1 to stage 2 of int2fp_pipe
package fp_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

  // Magnitude plus its leading-zero count; zero flags an all-zero magnitude,
  // in which case lz carries no meaning.
  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  lz;
    logic        zero;
  } i2f_s1_t;

endpackage

// File: rtl/LZC32.sv
`timescale 1ns/1ps
// LZC32: combinational 32-bit leading-zero counter.
//   Din : operand
//   Z   : number of leading zeros (valid only when AZ = 0)
//   AZ  : 1 when Din is all zeros
module LZC32 (
  input  logic [31:0] Din,
  output logic [4:0]  Z,
  output logic        AZ
);

  logic [5:0] cnt;
  logic       found;

  // Scan from the MSB; counting stops at the first set bit.
  always_comb begin
    cnt   = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (Din[i]) found = 1'b1;
        else        cnt   = cnt + 6'd1;
      end
    end
  end

  assign Z  = cnt[4:0];
  assign AZ = ~|Din;

endmodule

// File: rtl/int2fp_pipe.sv
`timescale 1ns/1ps
// int2fp_pipe: two-stage pipelined 32-bit integer to binary32 converter,
// round to nearest-even.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   in_data, in_signed   : operand and its interpretation (1 = two's complement)
//   out_valid / out_ready: result handshake
//   out_data             : binary32 {sign, exp, frac}
//   out_inexact          : rounding discarded nonzero bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and payload until that transfer; ready may
// depend combinationally on the downstream ready (in_ready follows out_ready
// when both stages are full). Capacity is two operands.
module int2fp_pipe
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  // Exponent of a value whose MSB sits at bit 31 of the normalised word.
  localparam logic [FP32_EXP_W-1:0] EXP_BASE = FP32_EXP_W'(FP32_BIAS + 31);

  logic    s1_valid, s2_valid;
  logic    s1_load, s2_load;
  i2f_s1_t s1_q, s1_d;
  fp32_t   s2_q, s2_d;
  logic    s2_inexact_q, s2_inexact_d;

  // ---------------- stage 1: magnitude and leading zeros ----------------
  logic        in_sign;
  logic [31:0] in_mag;
  logic [4:0]  lz;
  logic        az;

  assign in_sign = in_signed & in_data[31];
  // Negating 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  assign in_mag  = in_sign ? (~in_data + 32'd1) : in_data;

  LZC32 u_lzc (
    .Din (in_mag),
    .Z   (lz),
    .AZ  (az)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.mag  = in_mag;
    s1_d.lz   = lz;
    s1_d.zero = az;
  end

  // ---------------- stage 2: normalise, round, pack ----------------
  // Bit 31 of the normalised word is the implicit one and is dropped.
  logic [30:0] norm;
  logic        guard, sticky, rnd_up;
  logic [23:0] rsum;

  always_comb begin
    norm   = 31'(s1_q.mag << s1_q.lz);
    guard  = norm[7];
    sticky = |norm[6:0];
    rnd_up = guard & (sticky | norm[8]);
    // A carry out of the fraction means it rolled over to zero; the exponent
    // absorbs the carry. The largest result is 2^32, far below Inf.
    rsum   = {1'b0, norm[30:8]} + {23'd0, rnd_up};

    s2_d         = '0;
    s2_inexact_d = 1'b0;
    if (!s1_q.zero) begin
      s2_d.sign    = s1_q.sign;
      s2_d.exp     = EXP_BASE - {3'b000, s1_q.lz} + {7'd0, rsum[23]};
      s2_d.frac    = rsum[22:0];
      s2_inexact_d = guard | sticky;
    end
  end

  // ---------------- handshake ----------------
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      s2_q         <= '0;
      s2_inexact_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid     <= 1'b1;
      s2_q         <= s2_d;
      s2_inexact_q <= s2_inexact_d;
    end else if (out_ready) begin
      s2_valid     <= 1'b0;
    end
  end

  assign out_valid   = s2_valid;
  assign out_data    = s2_q;
  assign out_inexact = s2_inexact_q;

endmodule

// File: tb/tb_int2fp_pipe.sv
`timescale 1ns/1ps
// tb_int2fp_pipe: directed-vector bench for int2fp_pipe.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_int2fp_pipe;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_inexact;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries are {inexact, data}.
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  int2fp_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (out_data !== 32'h0 || out_inexact !== 1'b0) begin
      n_err++; $display("FAIL reset_out_data: got %h/%b want 00000000/0", out_data, out_inexact);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vd [11] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                             32'h00000000, 32'h01000001, 32'h01000003, 32'h80000000,
                             32'h7FFFFFFF, 32'h00FFFFFF, 32'hFFFFFFF6};
    logic        vs [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ve [11] = '{32'h3F800000, 32'hBF800000, 32'h4F800000, 32'hCF000000,
                             32'h00000000, 32'h4B800000, 32'h4B800002, 32'h4F000000,
                             32'h4F000000, 32'h4B7FFFFF, 32'hC1200000};
    logic        vx [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid  = 1'b1;
      in_data   = vd[i];
      in_signed = vs[i];
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== ve[i] || out_inexact !== vx[i]) begin
        n_err++;
        $display("FAIL dir%0d_result in=%h signed=%b: got v=%b %h x=%b want v=1 %h x=%b",
                 i, vd[i], vs[i], out_valid, out_data, out_inexact, ve[i], vx[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    logic [31:0] res [10] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                              32'h41000000, 32'h41100000};
    int idx = 0;
    int first_out = -1;
    int last_out = -1;
    logic [32:0] e;
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, res[i]});
    out_ready = 1'b1;
    in_signed = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (idx < 10);
      in_data  = 32'(idx);
      @(negedge clk);
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got %h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_inexact, out_data} !== e) begin
            n_err++; $display("FAIL stream_data cyc=%0d: got %b/%h want %b/%h",
                              cyc, out_inexact, out_data, e[32], e[31:0]);
          end
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx == 10 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL stream_timeout: got %0d results missing want 0", exp_q.size());
      exp_q.delete();
    end
    n_vec++;
    if (first_out != 2 || last_out != 11) begin
      n_err++; $display("FAIL stream_timing: got first=%0d last=%0d want 2/11", first_out, last_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0] ops [3] = '{32'd10, 32'd20, 32'd30};
    int cur = 0;
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'h41200000});
    exp_q.push_back({1'b0, 32'h41A00000});
    exp_q.push_back({1'b0, 32'h41F00000});
    out_ready = 1'b0;
    in_signed = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      in_data  = ops[cur];
      @(negedge clk);
      if (cyc >= 2) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL stall_in_ready cyc=%0d: got %b want 0", cyc, in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h41200000) begin
          n_err++; $display("FAIL stall_hold cyc=%0d: got v=%b %h want v=1 41200000",
                            cyc, out_valid, out_data);
        end
      end
      if (in_valid && in_ready) cur++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (cur != 2) begin
      n_err++; $display("FAIL stall_accepted: got %0d want 2", cur);
    end
    // Release while still full and still offering an operand: pop and push together.
    out_ready = 1'b1;
    in_data   = ops[cur];
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_pop_push_ready: got %b want 1", in_ready);
    end
    if (in_valid && in_ready) cur++;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        n_vec++;
        e = exp_q.pop_front();
        if ({out_inexact, out_data} !== e) begin
          n_err++; $display("FAIL drain_data: got %b/%h want %b/%h",
                            out_inexact, out_data, e[32], e[31:0]);
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0 || cur != 3) begin
      n_err++; $display("FAIL drain_done: got left=%0d accepted=%0d want 0/3", exp_q.size(), cur);
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd5;
    @(posedge clk); #1;
    in_data   = 32'd6;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL prefill: got v=%b rdy=%b want 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_err++; $display("FAIL midreset_async: got v=%b %h want 0 00000000", out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL midreset_stale cyc=%0d: got v=%b rdy=%b want 0/1",
                          cyc, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h40E00000) begin
      n_err++; $display("FAIL post_reset_conv: got v=%b %h want v=1 40E00000", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
